// File: rtl/openstrive_mem_arbiter.sv
// openstrive_mem_arbiter: round-robin arbiter sharing one single-port
// synchronous SRAM among NPORTS masters, with lock and in-order responses.
module openstrive_mem_arbiter #(
  parameter int NPORTS = 2,
  parameter int AW     = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS-1:0]    m_req,
  input  logic [NPORTS-1:0]    m_lock,
  input  logic [4*NPORTS-1:0]  m_wen,
  input  logic [AW*NPORTS-1:0] m_addr,
  input  logic [32*NPORTS-1:0] m_wdata,
  output logic [NPORTS-1:0]    m_gnt,
  output logic [NPORTS-1:0]    m_rvalid,
  output logic [31:0]          m_rdata,
  output logic                 mem_ena,
  output logic [3:0]           mem_wen,
  output logic [AW-1:0]        mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NPORTS - 1);

  logic [IW-1:0] last_gnt_q;
  logic [IW-1:0] last_gnt_d;
  logic          locked_q;
  logic          locked_d;
  logic          rsp_v_q;
  logic          rsp_v_d;
  logic [IW-1:0] rsp_id_q;
  logic [IW-1:0] rsp_id_d;

  logic          gnt_any;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] cand;
  logic          issue;
  logic [3:0]    sel_wen;

  // Scan downwards so the closest port after last_gnt wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (locked_q && m_req[last_gnt_q]) begin
      gnt_any = 1'b1;
      gnt_idx = last_gnt_q;
    end else begin
      for (int i = NPORTS; i >= 1; i--) begin
        cand = IW'((int'(last_gnt_q) + i) % NPORTS);
        if (m_req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign issue = gnt_any & ~rst;

  always_comb begin
    m_gnt     = '0;
    mem_ena   = 1'b0;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    sel_wen   = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (gnt_idx == IW'(p)) begin
        sel_wen   = m_wen[p*4 +: 4];
        mem_addr  = m_addr[p*AW +: AW];
        mem_wdata = m_wdata[p*32 +: 32];
      end
    end
    if (issue) begin
      m_gnt[gnt_idx] = 1'b1;
      mem_ena        = 1'b1;
      mem_wen        = sel_wen;
    end
  end

  always_comb begin
    m_rvalid = '0;
    if (rsp_v_q && !rst) begin
      m_rvalid[rsp_id_q] = 1'b1;
    end
  end

  assign m_rdata = mem_rdata;

  // A single port has nobody to lock out, so lock never sticks.
  always_comb begin
    last_gnt_d = last_gnt_q;
    locked_d   = 1'b0;
    rsp_v_d    = 1'b0;
    rsp_id_d   = rsp_id_q;
    if (issue) begin
      last_gnt_d = gnt_idx;
      locked_d   = (NPORTS > 1) && m_lock[gnt_idx];
      rsp_v_d    = 1'b1;
      rsp_id_d   = gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= LAST_RST;
      locked_q   <= 1'b0;
      rsp_v_q    <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      locked_q   <= locked_d;
      rsp_v_q    <= rsp_v_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

endmodule

// File: tb/tb_openstrive_mem_arbiter.sv
// tb_openstrive_mem_arbiter: directed and random traffic on a 3-port
// arbiter against a behavioural arbitration and memory reference model.
module tb_openstrive_mem_arbiter;

  localparam int NP = 3;
  localparam int AW = 22;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP-1:0]    m_req;
  logic [NP-1:0]    m_lock;
  logic [4*NP-1:0]  m_wen;
  logic [AW*NP-1:0] m_addr;
  logic [32*NP-1:0] m_wdata;
  logic [NP-1:0]    m_gnt;
  logic [NP-1:0]    m_rvalid;
  logic [31:0]      m_rdata;
  logic             mem_ena;
  logic [3:0]       mem_wen;
  logic [AW-1:0]    mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  always #5 clk = ~clk;

  openstrive_mem_arbiter #(.NPORTS(NP), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_lock(m_lock),
    .m_wen(m_wen), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .mem_ena(mem_ena), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // SRAM macro stand-in: registered read-before-write.
  logic [31:0] sram [0:63];
  logic [31:0] sram_q = 32'h0;
  assign mem_rdata = sram_q;
  always @(posedge clk) begin
    if (mem_ena) begin
      sram_q <= sram[mem_addr[5:0]];
      for (int b = 0; b < 4; b++)
        if (mem_wen[b])
          sram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Master-side request state
  logic [NP-1:0] req_v = '0;
  logic [NP-1:0] lock_v = '0;
  logic [3:0]    wen_a  [NP];
  logic [AW-1:0] addr_a [NP];
  logic [31:0]   wd_a   [NP];

  // Reference model state
  logic [31:0] ref_mem [0:63];
  int          mdl_last;
  bit          mdl_lock;
  bit          exp_rv;
  int          exp_id;
  logic [31:0] exp_data;
  int          waitc [NP];
  bit          exmp  [NP];
  int          eg_g;

  logic [NP-1:0] obs_gnt;
  logic [NP-1:0] obs_rv;
  logic [31:0]   obs_rd;

  function automatic int pick();
    int best = -1;
    int bd = NP + 1;
    if (mdl_lock && req_v[mdl_last]) return mdl_last;
    for (int p = 0; p < NP; p++) begin
      int d = (p - mdl_last - 1 + 2*NP) % NP;
      if (req_v[p] && d < bd) begin
        bd = d;
        best = p;
      end
    end
    return best;
  endfunction

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      m_req[p]            = req_v[p];
      m_lock[p]           = lock_v[p];
      m_wen[p*4 +: 4]     = wen_a[p];
      m_addr[p*AW +: AW]  = addr_a[p];
      m_wdata[p*32 +: 32] = wd_a[p];
    end
  endtask

  task automatic mdl_reset();
    mdl_last = NP - 1;
    mdl_lock = 0;
    exp_rv   = 0;
    exp_id   = 0;
    for (int p = 0; p < NP; p++) begin
      waitc[p] = 0;
      exmp[p]  = 0;
    end
  endtask

  // Entered at posedge+1; returns at the next posedge+1.
  task automatic step();
    int eg;
    bit lk;
    logic [5:0] a;
    drive();
    @(negedge clk);
    obs_gnt = m_gnt;
    obs_rv  = m_rvalid;
    obs_rd  = m_rdata;
    lk = mdl_lock && req_v[mdl_last];
    eg = pick();
    eg_g = eg;
    if (eg < 0) begin
      chk("gnt", m_gnt, 0);
      chk("ena", mem_ena, 0);
      chk("mwen", mem_wen, 0);
    end else begin
      chk("gnt", m_gnt, 1 << eg);
      chk("ena", mem_ena, 1);
      chk("mwen", mem_wen, wen_a[eg]);
      chk("maddr", mem_addr, addr_a[eg]);
      chk("mwdata", mem_wdata, wd_a[eg]);
    end
    chk("rvalid", m_rvalid, exp_rv ? (1 << exp_id) : 0);
    if (exp_rv) chk("rdata", m_rdata, exp_data);
    for (int p = 0; p < NP; p++) begin
      if (!req_v[p]) begin
        waitc[p] = 0;
        exmp[p]  = 0;
      end else if (eg >= 0 && p != eg) begin
        waitc[p]++;
        if (lk) exmp[p] = 1;
      end
    end
    if (eg >= 0) begin
      if (!exmp[eg]) chk("fair", waitc[eg] > NP - 1, 0);
      waitc[eg] = 0;
      exmp[eg]  = 0;
      a = addr_a[eg][5:0];
      exp_data = ref_mem[a];
      for (int b = 0; b < 4; b++)
        if (wen_a[eg][b]) ref_mem[a][8*b +: 8] = wd_a[eg][8*b +: 8];
      exp_rv   = 1;
      exp_id   = eg;
      mdl_last = eg;
      mdl_lock = lock_v[eg];
    end else begin
      exp_rv   = 0;
      mdl_lock = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive();
    @(negedge clk);
    chk("rst_gnt", m_gnt, 0);
    chk("rst_rv", m_rvalid, 0);
    chk("rst_ena", mem_ena, 0);
    chk("rst_wen", mem_wen, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mdl_reset();
  endtask

  task automatic set_port(int p, logic [3:0] w, logic [AW-1:0] ad,
                          logic [31:0] d);
    wen_a[p]  = w;
    addr_a[p] = ad;
    wd_a[p]   = d;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      sram[i]    = ref_mem[i];
    end
    for (int p = 0; p < NP; p++) set_port(p, 4'h0, '0, 32'h0);
    mdl_reset();
    drive();
    @(posedge clk);
    #1;
    reset_dut();

    // 1: single read
    ref_mem[6'h10] = 32'hCAFEBABE;
    sram[6'h10]    = 32'hCAFEBABE;
    set_port(0, 4'h0, 22'h10, 32'h0);
    req_v = 3'b001;
    step();
    chk("t1_gnt", obs_gnt, 3'b001);
    req_v = 3'b000;
    step();
    chk("t1_rv", obs_rv, 3'b001);
    chk("t1_rd", obs_rd, 32'hCAFEBABE);

    // 2: two-port alternation
    reset_dut();
    set_port(0, 4'h0, 22'h3, 32'h0);
    set_port(1, 4'h0, 22'h4, 32'h0);
    req_v = 3'b011;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t2_gnt", obs_gnt, (i % 2 == 0) ? 3'b001 : 3'b010);
      if (i > 0) chk("t2_rv", obs_rv, (i % 2 == 1) ? 3'b001 : 3'b010);
    end
    req_v = 3'b000;
    step();
    chk("t2_rv_last", obs_rv, 3'b010);

    // 3: byte-masked write then read back
    ref_mem[6'h20] = 32'hFFFFFFFF;
    sram[6'h20]    = 32'hFFFFFFFF;
    set_port(1, 4'b0101, 22'h20, 32'h11223344);
    req_v = 3'b010;
    step();
    req_v = 3'b000;
    step();
    chk("t3_wr_rv", obs_rv, 3'b010);
    chk("t3_wr_rd", obs_rd, 32'hFFFFFFFF);
    set_port(1, 4'h0, 22'h20, 32'h0);
    req_v = 3'b010;
    step();
    req_v = 3'b000;
    step();
    chk("t3_rd", obs_rd, 32'hFF22FF44);

    // 4: lock holds port0 while port1 waits
    reset_dut();
    set_port(0, 4'h0, 22'h1, 32'h0);
    set_port(1, 4'h0, 22'h2, 32'h0);
    req_v  = 3'b011;
    lock_v = 3'b001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_lock", obs_gnt, 3'b001);
    end
    req_v  = 3'b010;
    lock_v = 3'b000;
    step();
    chk("t4_rel", obs_gnt, 3'b010);
    req_v = 3'b000;
    step();

    // 5: reset right after a grant
    req_v = 3'b001;
    step();
    req_v = 3'b011;
    reset_dut();
    step();
    chk("t5_first", obs_gnt, 3'b001);
    chk("t5_rv", obs_rv, 3'b000);
    req_v = 3'b000;
    step();

    // 6: random traffic
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!req_v[p]) begin
          if ($urandom_range(3) != 0) begin
            req_v[p] = 1'b1;
            set_port(p, ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0,
                     AW'($urandom_range(63)), $urandom);
          end
        end else if ($urandom_range(15) == 0) begin
          req_v[p] = 1'b0;
        end
        lock_v[p] = ($urandom_range(3) == 0);
      end
      step();
      if (eg_g >= 0) req_v[eg_g] = 1'b0;
    end
    req_v  = '0;
    lock_v = '0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
